// File: rtl/proc_sequencer.sv
// Instruction issuer for the 8-bit four-register processor: runs a small loadable
// program and waits for Done after each instruction, with a WAIT timeout.
module proc_sequencer #(
  parameter int AW      = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ProgWe,
  input  logic [AW-1:0] ProgAddr,
  input  logic [13:0]   ProgData,
  input  logic          Start,
  input  logic [AW:0]   Length,
  input  logic          Done,
  input  logic [7:0]    BusWires,
  output logic          w,
  output logic [1:0]    F,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic [7:0]    Data,
  output logic          Busy,
  output logic          Finished,
  output logic          Error,
  output logic [AW-1:0] PC,
  output logic [7:0]    LastBus,
  output logic [AW:0]   IssueCount,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FIN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [13:0]   mem [DEPTH];
  state_t        state, state_nxt;
  logic [13:0]   instr, instr_nxt;
  logic [AW:0]   len_q, len_nxt, len_clamp, count_nxt;
  logic [AW-1:0] pc_nxt;
  logic [7:0]    last_nxt;
  logic [TW-1:0] tmo, tmo_nxt;

  assign len_clamp = (Length > DEPTH_W) ? DEPTH_W : Length;

  // Program memory is never reset; writes are locked out while a run is in flight.
  always_ff @(posedge Clock) begin
    if (ProgWe && (state == S_IDLE || state == S_FIN || state == S_ERR))
      mem[ProgAddr] <= ProgData;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      instr      <= '0;
      len_q      <= '0;
      IssueCount <= '0;
      PC         <= '0;
      LastBus    <= '0;
      tmo        <= '0;
    end else begin
      state      <= state_nxt;
      instr      <= instr_nxt;
      len_q      <= len_nxt;
      IssueCount <= count_nxt;
      PC         <= pc_nxt;
      LastBus    <= last_nxt;
      tmo        <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    instr_nxt = instr;
    len_nxt   = len_q;
    count_nxt = IssueCount;
    pc_nxt    = PC;
    last_nxt  = LastBus;
    tmo_nxt   = tmo;
    case (state)
      S_IDLE, S_ERR: begin
        if (Start) begin
          len_nxt   = len_clamp;
          pc_nxt    = '0;
          count_nxt = '0;
          tmo_nxt   = '0;
          if (len_clamp == '0) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_ISSUE;
            instr_nxt = mem[AW'(0)];
          end
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
        tmo_nxt   = '0;
      end
      S_WAIT: begin
        if (Done) begin
          last_nxt  = BusWires;
          count_nxt = IssueCount + 1'b1;
          pc_nxt    = PC + 1'b1;
          if (count_nxt == len_q) begin
            state_nxt = S_FIN;
          end else begin
            // Back-to-back: the processor is at T0 again in the next cycle.
            state_nxt = S_ISSUE;
            instr_nxt = mem[pc_nxt];
          end
        end else begin
          tmo_nxt = tmo + 1'b1;
          if (tmo_nxt == TW'(TIMEOUT))
            state_nxt = S_ERR;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign w         = (state == S_ISSUE);
  assign Busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign Finished  = (state == S_FIN);
  assign Error     = (state == S_ERR);
  assign F         = instr[13:12];
  assign Rx        = instr[11:10];
  assign Ry        = instr[9:8];
  assign Data      = instr[7:0];
  assign state_dbg = state;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a small behavioural model of the processor
// (load/mv Done one cycle after T0, add/sub three cycles after T0).
module tb_proc_sequencer;

  logic       Clock, Reset, ProgWe, Start, Done;
  logic [3:0] ProgAddr;
  logic [13:0] ProgData;
  logic [4:0] Length;
  logic [7:0] BusWires;
  logic       w, Busy, Finished, Error;
  logic [1:0] F, Rx, Ry;
  logic [7:0] Data, LastBus;
  logic [3:0] PC;
  logic [4:0] IssueCount;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  proc_sequencer #(.AW(4), .DEPTH(16), .TIMEOUT(7)) dut (
    .Clock(Clock), .Reset(Reset), .ProgWe(ProgWe), .ProgAddr(ProgAddr),
    .ProgData(ProgData), .Start(Start), .Length(Length), .Done(Done),
    .BusWires(BusWires), .w(w), .F(F), .Rx(Rx), .Ry(Ry), .Data(Data),
    .Busy(Busy), .Finished(Finished), .Error(Error), .PC(PC),
    .LastBus(LastBus), .IssueCount(IssueCount), .state_dbg(state_dbg)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Processor model
  logic       proc_en;
  logic [7:0] regs [4];
  logic [1:0] pf, prx, pry;
  int         pstep;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pstep <= 0; Done <= 1'b0; BusWires <= 8'h00;
      pf <= 2'b00; prx <= 2'b00; pry <= 2'b00;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else begin
      Done <= 1'b0;
      if (w) begin
        pf <= F; prx <= Rx; pry <= Ry; pstep <= 1;
        if (!F[1]) begin
          Done <= proc_en;
          BusWires <= (F == 2'b00) ? Data : regs[Ry];
        end
      end else if (pstep == 1 && pf[1]) begin
        pstep <= 2;
      end else if (pstep == 2) begin
        pstep <= 3;
        Done <= proc_en;
        BusWires <= (pf == 2'b10) ? regs[prx] + regs[pry] : regs[prx] - regs[pry];
      end
      if (Done) begin
        regs[prx] <= BusWires;
        pstep <= 0;
      end
    end
  end

  // Observations from the most recent run
  int         fin_cycle, err_cycle, w_cnt, busy_cnt, bus_n, max_pc;
  logic [7:0] bus_log [32];
  logic [7:0] data_log [64];
  logic [63:0] w_vec;

  function automatic logic [13:0] enc(input logic [1:0] f, input logic [1:0] rx,
                                      input logic [1:0] ry, input logic [7:0] d);
    return {f, rx, ry, d};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [13:0] d);
    ProgWe = 1'b1; ProgAddr = a; ProgData = d;
    tick();
    ProgWe = 1'b0;
  endtask

  // Cycle 0 is the cycle Start is high; outputs are sampled once per cycle.
  task automatic run_prog(input logic [4:0] len, input bit disturb, input int limit);
    logic d;
    fin_cycle = -1; err_cycle = -1; w_cnt = 0; busy_cnt = 0; bus_n = 0; max_pc = 0;
    w_vec = '0;
    Start = 1'b1; Length = len;
    tick();
    Start = 1'b0; Length = 5'd2;
    for (int c = 1; c <= limit && c < 64; c++) begin
      w_vec[c] = w;
      data_log[c] = Data;
      if (w) w_cnt++;
      if (Busy) busy_cnt++;
      if (int'(PC) > max_pc) max_pc = int'(PC);
      if (Finished && fin_cycle < 0) fin_cycle = c;
      if (Error && err_cycle < 0) err_cycle = c;
      if (disturb) begin
        Start = (c == 3);
        ProgWe = (c == 5); ProgAddr = 4'd0; ProgData = 14'h3fff;
      end
      d = Done;
      if (fin_cycle >= 0 || err_cycle >= 0) break;
      tick();
      if (d && bus_n < 32) begin
        bus_log[bus_n] = LastBus;
        bus_n++;
      end
    end
    Start = 1'b0; ProgWe = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL reset_w: got %b expected 0", w); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Finished !== 1'b0) begin errors++; $display("FAIL reset_finished: got %b expected 0", Finished); end
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", Error); end
    checks++; if (PC !== 4'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", PC); end
    checks++; if (LastBus !== 8'd0) begin errors++; $display("FAIL reset_lastbus: got %0d expected 0", LastBus); end
    checks++; if (IssueCount !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", IssueCount); end
    checks++; if ({F, Rx, Ry, Data} !== 14'd0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {F, Rx, Ry, Data}); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic check_program_run(input string tag);
    logic [7:0] exp_bus [5];
    exp_bus[0] = 8'd5; exp_bus[1] = 8'd3; exp_bus[2] = 8'd8; exp_bus[3] = 8'd5; exp_bus[4] = 8'd5;
    // 1 (Start) + 2 + 2 + 4 + 4 + 2 then FIN
    checks++; if (fin_cycle != 15) begin errors++; $display("FAIL %s_fin_cycle: got %0d expected 15", tag, fin_cycle); end
    checks++; if (w_cnt != 5) begin errors++; $display("FAIL %s_w_count: got %0d expected 5", tag, w_cnt); end
    // w at cycles 1, 3, 5, 9, 13
    checks++; if (w_vec[15:0] !== 16'h222a) begin errors++; $display("FAIL %s_w_cycles: got %h expected 222a", tag, w_vec[15:0]); end
    checks++; if (bus_n != 5) begin errors++; $display("FAIL %s_done_count: got %0d expected 5", tag, bus_n); end
    for (int i = 0; i < 5 && i < bus_n; i++) begin
      checks++;
      if (bus_log[i] !== exp_bus[i]) begin errors++; $display("FAIL %s_lastbus[%0d]: got %0d expected %0d", tag, i, bus_log[i], exp_bus[i]); end
    end
    checks++; if (data_log[2] !== 8'd5 || data_log[4] !== 8'd3) begin errors++; $display("FAIL %s_data_hold: got %0d,%0d expected 5,3", tag, data_log[2], data_log[4]); end
    checks++; if (IssueCount !== 5'd5) begin errors++; $display("FAIL %s_count: got %0d expected 5", tag, IssueCount); end
    checks++; if (PC !== 4'd5) begin errors++; $display("FAIL %s_pc: got %0d expected 5", tag, PC); end
    tick();
    checks++; if (Finished !== 1'b0 || state_dbg !== 3'd0) begin errors++; $display("FAIL %s_fin_pulse: got fin=%b state=%0d expected 0,0", tag, Finished, state_dbg); end
  endtask

  task automatic test_program();
    write_mem(4'd0, enc(2'b00, 2'd0, 2'd0, 8'd5)); // load R0,5
    write_mem(4'd1, enc(2'b00, 2'd1, 2'd0, 8'd3)); // load R1,3
    write_mem(4'd2, enc(2'b10, 2'd0, 2'd1, 8'd0)); // add R0,R1
    write_mem(4'd3, enc(2'b11, 2'd0, 2'd1, 8'd0)); // sub R0,R1
    write_mem(4'd4, enc(2'b01, 2'd2, 2'd0, 8'd0)); // mv R2,R0
    run_prog(5'd5, 1'b0, 40);
    check_program_run("prog");
  endtask

  task automatic test_back_to_back_disturbed();
    run_prog(5'd5, 1'b1, 40);
    check_program_run("disturb");
    run_prog(5'd1, 1'b0, 10);
    checks++; if (data_log[1] !== 8'd5) begin errors++; $display("FAIL mem_kept_data: got %h expected 05", data_log[1]); end
    checks++; if (fin_cycle != 3) begin errors++; $display("FAIL mem_kept_fin: got %0d expected 3", fin_cycle); end
    tick();
  endtask

  task automatic test_zero_length();
    run_prog(5'd0, 1'b0, 10);
    checks++; if (fin_cycle != 1) begin errors++; $display("FAIL zero_fin_cycle: got %0d expected 1", fin_cycle); end
    checks++; if (w_cnt != 0) begin errors++; $display("FAIL zero_w: got %0d expected 0", w_cnt); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy: got %0d expected 0", busy_cnt); end
    tick();
  endtask

  task automatic test_timeout();
    proc_en = 1'b0;
    run_prog(5'd1, 1'b0, 30);
    // ISSUE at cycle 1, seven WAIT cycles 2..8, ERR visible at 9
    checks++; if (err_cycle != 9) begin errors++; $display("FAIL tmo_err_cycle: got %0d expected 9", err_cycle); end
    checks++; if (w_cnt != 1) begin errors++; $display("FAIL tmo_w: got %0d expected 1", w_cnt); end
    checks++; if (Busy !== 1'b0 || w !== 1'b0) begin errors++; $display("FAIL tmo_busy: got busy=%b w=%b expected 0,0", Busy, w); end
    repeat (3) tick();
    checks++; if (Error !== 1'b1 || state_dbg !== 3'd4) begin errors++; $display("FAIL tmo_sticky: got err=%b state=%0d expected 1,4", Error, state_dbg); end
    proc_en = 1'b1;
    run_prog(5'd1, 1'b0, 10);
    checks++; if (err_cycle != -1 || fin_cycle != 3) begin errors++; $display("FAIL tmo_restart: got err=%0d fin=%0d expected -1,3", err_cycle, fin_cycle); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    Start = 1'b1; Length = 5'd5;
    tick();
    Start = 1'b0;
    repeat (6) tick(); // cycle 7: WAIT of the add
    checks++; if (state_dbg !== 3'd2 || PC !== 4'd2) begin errors++; $display("FAIL mid_pre: got state=%0d pc=%0d expected 2,2", state_dbg, PC); end
    #3 Reset = 1'b1;
    #1;
    checks++; if (w !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mid_w_busy: got w=%b busy=%b expected 0,0", w, Busy); end
    checks++; if (PC !== 4'd0 || LastBus !== 8'd0) begin errors++; $display("FAIL mid_pc_bus: got pc=%0d bus=%0d expected 0,0", PC, LastBus); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL mid_state: got %0d expected 0", state_dbg); end
    #1 Reset = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 16; i++)
      write_mem(4'(i), enc(2'b00, 2'(i % 4), 2'd0, 8'(i * 3 + 1)));
    run_prog(5'd31, 1'b0, 60);
    checks++; if (fin_cycle != 33) begin errors++; $display("FAIL clamp_fin_cycle: got %0d expected 33", fin_cycle); end
    checks++; if (w_cnt != 16) begin errors++; $display("FAIL clamp_w: got %0d expected 16", w_cnt); end
    checks++; if (IssueCount !== 5'd16) begin errors++; $display("FAIL clamp_count: got %0d expected 16", IssueCount); end
    checks++; if (max_pc != 15) begin errors++; $display("FAIL clamp_pc: got %0d expected 15", max_pc); end
    checks++; if (LastBus !== 8'd46) begin errors++; $display("FAIL clamp_lastbus: got %0d expected 46", LastBus); end
    tick();
  endtask

  initial begin
    Reset = 1'b1; ProgWe = 1'b0; ProgAddr = '0; ProgData = '0;
    Start = 1'b0; Length = '0; proc_en = 1'b1;
    test_reset();
    test_program();
    test_back_to_back_disturbed();
    test_zero_length();
    test_timeout();
    test_reset_mid_run();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
